areg_pipe: RTL and testbench

AREG_PIPE -- requirements
Module: areg_pipe

---
 rtl/areg_pipe.sv | 156 +++++++++++++++
 tb/tb_areg_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/areg_pipe.sv
`default_nettype none
// ============================================================================
// areg_pipe : register file with a one-entry write pipeline, read bypass,
//             optional lower-to-upper mirroring and a sequential clear sweep.
// Revision  : 1.0
// ============================================================================
module areg_pipe #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int NREAD  = 2,
  parameter int MIRROR = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NREAD*$clog2(DEPTH)-1:0]     ra,
  output logic [NREAD*WIDTH-1:0]             rval,
  input  logic                               w_valid,
  output logic                               w_ready,
  input  logic [1:0]                         w_mode,
  input  logic [$clog2(DEPTH)-1:0]           wa,
  input  logic [WIDTH-1:0]                   wval,
  input  logic                               clr,
  output logic                               busy
);

  localparam int             AW   = $clog2(DEPTH);
  localparam logic [AW-1:0]  HALF = AW'(DEPTH / 2);
  localparam logic [AW-1:0]  LAST = AW'(DEPTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  localparam logic [1:0] MODE_SET = 2'b00;
  localparam logic [1:0] MODE_ADD = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b10;
  localparam logic [1:0] MODE_XOR = 2'b11;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             pv_q, pv_d;
  logic [AW-1:0]    pa_q, pa_d;
  logic [1:0]       pm_q, pm_d;
  logic [WIDTH-1:0] po_q, po_d;

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] commit_val;
  logic             mirror_en;
  logic [AW-1:0]    mirror_addr;
  logic             accept;

  assign w_ready = (state_q == IDLE) && !clr;
  assign busy    = (state_q == SWEEP);
  assign accept  = w_valid && w_ready;

  // The pending op is resolved against committed contents, so back-to-back
  // writes to one address chain correctly without a forwarding path.
  always_comb begin
    old_val     = mem_q[pa_q];
    commit_val  = old_val;
    mirror_en   = (MIRROR != 0) && (pa_q[AW-1] == 1'b0);
    mirror_addr = pa_q | HALF;
    case (pm_q)
      MODE_SET: commit_val = po_q;
      MODE_ADD: commit_val = old_val + po_q;
      MODE_SUB: commit_val = old_val - po_q;
      MODE_XOR: commit_val = old_val ^ po_q;
      default:  commit_val = po_q;
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    pv_d    = 1'b0;
    pa_d    = pa_q;
    pm_d    = pm_q;
    po_d    = po_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (pv_q) begin
      mem_d[pa_q] = commit_val;
      if (mirror_en) begin
        mem_d[mirror_addr] = commit_val;
      end
    end

    if (accept) begin
      pv_d = 1'b1;
      pa_d = wa;
      pm_d = w_mode;
      po_d = wval;
    end

    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pv_q    <= 1'b0;
      pa_q    <= '0;
      pm_q    <= '0;
      po_q    <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      pv_q    <= pv_d;
      pa_q    <= pa_d;
      pm_q    <= pm_d;
      po_q    <= po_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reads of the pending target (or its mirror) see the value about to land.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_val;

    assign rd_addr = ra[k*AW +: AW];

    always_comb begin
      rd_val = mem_q[rd_addr];
      if (pv_q && ((rd_addr == pa_q) || (mirror_en && (rd_addr == mirror_addr)))) begin
        rd_val = commit_val;
      end
    end

    assign rval[k*WIDTH +: WIDTH] = rd_val;
  end

endmodule
`default_nettype wire

// File: tb/tb_areg_pipe.sv
`default_nettype none
// ============================================================================
// tb_areg_pipe : scoreboard bench for areg_pipe (WIDTH=16, DEPTH=16, NREAD=2).
// Revision     : 1.0
// ============================================================================
module tb_areg_pipe;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int NREAD = 2;
  localparam int AW    = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREAD*AW-1:0]    ra;
  logic [NREAD*WIDTH-1:0] rval;
  logic                   w_valid;
  logic                   w_ready;
  logic [1:0]             w_mode;
  logic [AW-1:0]          wa;
  logic [WIDTH-1:0]       wval;
  logic                   clr;
  logic                   busy;

  always #5 clk = ~clk;

  areg_pipe #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .NREAD  (NREAD),
    .MIRROR (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ra      (ra),
    .rval    (rval),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .w_mode  (w_mode),
    .wa      (wa),
    .wval    (wval),
    .clr     (clr),
    .busy    (busy)
  );

  typedef struct packed {
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] v;
  } exp_t;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] model [DEPTH];
  exp_t             sb [$];
  string            sb_tag [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [1:0] m, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] nv;
    case (m)
      2'b00:   nv = v;
      2'b01:   nv = model[a] + v;
      2'b10:   nv = model[a] - v;
      default: nv = model[a] ^ v;
    endcase
    model[a] = nv;
    if (a < AW'(DEPTH / 2)) model[a + AW'(DEPTH / 2)] = nv;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [1:0] m, input logic [WIDTH-1:0] v);
    wa      = a;
    w_mode  = m;
    wval    = v;
    w_valid = 1'b1;
    #1;
    check_val("w_ready_before_write", {31'b0, w_ready}, 32'd1);
    step();
    w_valid = 1'b0;
    model_write(a, m, v);
  endtask

  task automatic expect_rd(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    exp_t  e;
    string t;
    sb.push_back('{a: a0, v: model[a0]});
    sb_tag.push_back({tag, "_p0"});
    sb.push_back('{a: a1, v: model[a1]});
    sb_tag.push_back({tag, "_p1"});
    ra = {a1, a0};
    #1;
    e = sb.pop_front();
    t = sb_tag.pop_front();
    check_val(t, {16'b0, rval[0 +: WIDTH]}, {16'b0, e.v});
    e = sb.pop_front();
    t = sb_tag.pop_front();
    check_val(t, {16'b0, rval[WIDTH +: WIDTH]}, {16'b0, e.v});
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < DEPTH / 2; i++) begin
      expect_rd(tag, AW'(i), AW'(i + DEPTH / 2));
      step();
    end
  endtask

  initial begin
    int busy_cycles;
    rst     = 1'b1;
    w_valid = 1'b0;
    clr     = 1'b0;
    w_mode  = 2'b00;
    wa      = '0;
    wval    = '0;
    ra      = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    check_val("reset_busy", {31'b0, busy}, 32'd0);
    check_val("reset_w_ready", {31'b0, w_ready}, 32'd1);
    expect_rd("reset_rval", 4'd0, 4'd15);
    step();

    // set with bypass on both the target and its mirror
    write(4'd3, 2'b00, 16'h1234);
    expect_rd("set_bypass", 4'd3, 4'd11);
    check_val("set_bypass_const", {16'b0, rval[WIDTH +: WIDTH]}, 32'h1234);
    step();
    expect_rd("set_commit", 4'd3, 4'd11);
    check_val("set_commit_const", {16'b0, rval[0 +: WIDTH]}, 32'h1234);

    // arithmetic chain, writes accepted back to back
    write(4'd5, 2'b00, 16'hFFFF);
    write(4'd5, 2'b01, 16'h0002);
    expect_rd("add", 4'd5, 4'd13);
    check_val("add_const", {16'b0, rval[0 +: WIDTH]}, 32'h0001);
    write(4'd5, 2'b10, 16'h0003);
    expect_rd("sub", 4'd5, 4'd13);
    check_val("sub_const", {16'b0, rval[0 +: WIDTH]}, 32'hFFFE);
    write(4'd5, 2'b11, 16'h00FF);
    expect_rd("xor", 4'd5, 4'd13);
    check_val("xor_const", {16'b0, rval[WIDTH +: WIDTH]}, 32'hFF01);
    step();

    // upper-half write must not mirror downward
    write(4'd12, 2'b00, 16'h0007);
    expect_rd("no_down_mirror", 4'd4, 4'd12);
    check_val("no_down_mirror_const", {16'b0, rval[0 +: WIDTH]}, 32'h0000);
    step();

    // two consecutive add-1 writes with no gap
    write(4'd2, 2'b01, 16'h0001);
    write(4'd2, 2'b01, 16'h0001);
    step();
    expect_rd("b2b_add", 4'd2, 4'd10);
    check_val("b2b_add_const", {16'b0, rval[0 +: WIDTH]}, 32'h0002);
    check_val("b2b_add_mirror_const", {16'b0, rval[WIDTH +: WIDTH]}, 32'h0002);
    step();

    // clr and write together: clr wins
    wa      = 4'd1;
    w_mode  = 2'b00;
    wval    = 16'hBEEF;
    w_valid = 1'b1;
    clr     = 1'b1;
    #1;
    check_val("clr_blocks_write", {31'b0, w_ready}, 32'd0);
    step();
    w_valid = 1'b0;
    clr     = 1'b0;
    model_clear();
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      busy_cycles++;
      clr = (k == 3);
      step();
    end
    clr = 1'b0;
    check_val("busy_cycles", busy_cycles, 32'd16);
    check_val("post_clr_w_ready", {31'b0, w_ready}, 32'd1);
    check_all("swept");

    // reset in the middle of a sweep
    write(4'd9, 2'b00, 16'h55AA);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (5) step();
    expect_rd("sweep_read", 4'd0, 4'd9);
    check_val("sweep_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    check_val("rst_sweep_busy", {31'b0, busy}, 32'd0);
    check_all("rst_sweep");

    // reset with the pending stage occupied
    write(4'd6, 2'b00, 16'h1111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    expect_rd("rst_stage", 4'd6, 4'd14);
    step();
    expect_rd("rst_stage_after", 4'd6, 4'd14);
    check_val("rst_stage_w_ready", {31'b0, w_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
